// File: rtl/dst_wb_writer.sv
// Destination write stage: buffers the 64-bit m_dst stream and drains it as 32-bit
// Wishbone incrementing bursts. Define DST_BSWAP_EN to byte-reverse each 32-bit beat.
module dst_wb_writer #(
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int BURST_LEN = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m_dst_putn,
    input  logic [63:0] m_dst,
    input  logic        m_dst_last,
    output logic        m_dst_full,
    output logic        m_dst_almost_full,
    input  logic [31:0] dst_addr,
    input  logic        dst_start,
    output logic        dst_busy,
    output logic        dst_done,
    output logic        dst_err,
    output logic        dst_ovf,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_BURST = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    logic [64:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, lastcnt_q;
    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   dat_q, dat_d;
    logic [2:0]    cti_q, cti_d;
    logic          cyc_q, cyc_d;
    logic          hi_q, hi_d;
    logic [CW-1:0] ent_left_q, ent_left_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    logic          full_s, push_s, pop_s, go_s, wb_ack_s, wb_err_s;
    logic [64:0]   head_s, next_s;
    logic [31:0]   first_last_s, bnd_s, size_s;
    logic          unused_s;

    assign full_s            = (count_q == CW'(DEPTH));
    assign m_dst_full        = full_s;
    assign m_dst_almost_full = (count_q >= CW'(DEPTH - AF_MARGIN));
    assign push_s            = ~m_dst_putn & ~full_s;
    assign head_s            = mem_q[rd_ptr_q];
    assign next_s            = mem_q[rd_ptr_q + AW'(1)];
    assign wb_err_s          = cyc_q & wbm_err_i;
    assign wb_ack_s          = cyc_q & wbm_ack_i & ~wbm_err_i;
    assign pop_s             = ((state_q == S_BURST) & wb_ack_s & hi_q)
                             | ((state_q == S_ERR) & (count_q != '0));
    assign go_s              = (count_q >= CW'(BURST_LEN)) | (lastcnt_q != '0);
    assign unused_s          = ^{dst_addr[2:0], size_s[31:CW], next_s[64:32]};

    // FIFO storage; contents are only meaningful below count_q, so no reset
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {m_dst_last, m_dst};
        end
    end

    // FIFO pointers, occupancy and number of buffered last-flagged entries
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            lastcnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_q + {{(AW-1){1'b0}}, push_s};
            rd_ptr_q  <= rd_ptr_q + {{(AW-1){1'b0}}, pop_s};
            count_q   <= count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
            lastcnt_q <= lastcnt_q + {{AW{1'b0}}, push_s & m_dst_last}
                                   - {{AW{1'b0}}, pop_s & head_s[64]};
        end
    end

    // Burst size: min of occupancy, burst length, run up to first last flag, 4 KB room
    always_comb begin
        first_last_s = 32'(BURST_LEN);
        for (int i = BURST_LEN - 1; i >= 0; i--) begin
            first_last_s = ((i < int'(count_q)) && mem_q[rd_ptr_q + AW'(i)][64])
                         ? 32'(i + 1) : first_last_s;
        end
        bnd_s  = 32'd512 - {23'd0, addr_q[11:3]};
        size_s = {{(32-CW){1'b0}}, count_q};
        size_s = (size_s > 32'(BURST_LEN)) ? 32'(BURST_LEN) : size_s;
        size_s = (size_s > first_last_s) ? first_last_s : size_s;
        size_s = (size_s > bnd_s) ? bnd_s : size_s;
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = dst_start ? S_WAIT : S_IDLE;
            S_WAIT:  state_d = go_s ? S_BURST : S_WAIT;
            S_BURST: begin
                if (wb_err_s) begin
                    state_d = S_ERR;
                end else if (wb_ack_s && hi_q && (ent_left_q == CW'(1))) begin
                    state_d = head_s[64] ? S_DONE : S_WAIT;
                end else begin
                    state_d = S_BURST;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = ((count_q != '0) && head_s[64]) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; the first BURST cycle only raises cyc/stb
    always_comb begin
        addr_d     = addr_q;
        dat_d      = dat_q;
        cti_d      = cti_q;
        cyc_d      = cyc_q;
        hi_d       = hi_q;
        ent_left_d = ent_left_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (dst_start) begin
                    addr_d = {dst_addr[31:3], 3'b000};
                    err_d  = 1'b0;
                    ovf_d  = 1'b0;
                end else begin
                    addr_d = addr_q;
                end
            end
            S_WAIT: begin
                cyc_d = 1'b0;
                if (go_s) begin
                    ent_left_d = size_s[CW-1:0];
                    hi_d       = 1'b0;
                end else begin
                    ent_left_d = ent_left_q;
                end
            end
            S_BURST: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    hi_d  = 1'b0;
                    dat_d = head_s[31:0];
                    cti_d = 3'b010;
                end else if (wb_err_s) begin
                    cyc_d = 1'b0;
                    err_d = 1'b1;
                end else if (wb_ack_s) begin
                    addr_d = addr_q + 32'd4;
                    if (!hi_q) begin
                        hi_d  = 1'b1;
                        dat_d = head_s[63:32];
                        cti_d = (ent_left_q == CW'(1)) ? 3'b111 : 3'b010;
                    end else begin
                        hi_d       = 1'b0;
                        ent_left_d = ent_left_q - CW'(1);
                        if (ent_left_q == CW'(1)) begin
                            cyc_d = 1'b0;
                        end else begin
                            dat_d = next_s[31:0];
                            cti_d = 3'b010;
                        end
                    end
                end else begin
                    cyc_d = 1'b1;
                end
            end
            default: cyc_d = 1'b0;
        endcase
        ovf_d = ovf_d | (~m_dst_putn & full_s);
    end

    assign busy_d = (state_d == S_WAIT) | (state_d == S_BURST) | (state_d == S_ERR);
    assign done_d = (state_d == S_DONE);

    // Registered bus and status outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            addr_q     <= '0;
            dat_q      <= '0;
            cti_q      <= 3'b000;
            cyc_q      <= 1'b0;
            hi_q       <= 1'b0;
            ent_left_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            cti_q      <= cti_d;
            cyc_q      <= cyc_d;
            hi_q       <= hi_d;
            ent_left_q <= ent_left_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign wbm_adr_o = addr_q;
    assign wbm_sel_o = 4'hF;
    assign wbm_we_o  = cyc_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_cti_o = cti_q;
    assign wbm_bte_o = 2'b00;
    assign dst_busy  = busy_q;
    assign dst_done  = done_q;
    assign dst_err   = err_q;
    assign dst_ovf   = ovf_q;

`ifdef DST_BSWAP_EN
    assign wbm_dat_o = {dat_q[7:0], dat_q[15:8], dat_q[23:16], dat_q[31:24]};
`else
    assign wbm_dat_o = dat_q;
`endif

endmodule

// File: tb/tb_dst_wb_writer.sv
// Bench for dst_wb_writer: vector table, hand-written corner sequences and random
// operations, all checked against a burst-splitting reference model.
module tb_dst_wb_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        wb_rst_i = 1'b1;
    logic        m_dst_putn = 1'b1;
    logic [63:0] m_dst = '0;
    logic        m_dst_last = 1'b0;
    logic [31:0] dst_addr = '0;
    logic        dst_start = 1'b0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        m_dst_full, m_dst_almost_full, dst_busy, dst_done, dst_err, dst_ovf;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;

    dst_wb_writer dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .m_dst_putn(m_dst_putn), .m_dst(m_dst), .m_dst_last(m_dst_last),
        .m_dst_full(m_dst_full), .m_dst_almost_full(m_dst_almost_full),
        .dst_addr(dst_addr), .dst_start(dst_start), .dst_busy(dst_busy),
        .dst_done(dst_done), .dst_err(dst_err), .dst_ovf(dst_ovf),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        int          n;
        int          exp_b;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    beat_t       got_q[$];
    beat_t       exp_q[$];
    logic [63:0] words[16];
    vec_t        tbl[7];

    bit    ack_en = 1'b1;
    int    err_at = -1;
    int    beat_idx = 0;
    bit    err_fired = 1'b0;
    bit    held_v = 1'b0;
    bit    last_final = 1'b0;
    beat_t held_b, mon_cur;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Wishbone slave: random acks, optional error on a chosen beat, beat logging
    always @(negedge clk) begin
        mon_cur = '{adr: wbm_adr_o, dat: wbm_dat_o, cti: wbm_cti_o};
        if (last_final) chk("gap_after_final", wbm_cyc_o, 0);
        last_final = 1'b0;
        if (held_v && wbm_stb_o) chk("held_stable", mon_cur, held_b);
        held_v = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        if (wbm_stb_o) begin
            chk("bus_static", {wbm_we_o, wbm_sel_o, wbm_bte_o}, {1'b1, 4'hF, 2'b00});
            if (beat_idx == err_at) begin
                wbm_err_i = 1'b1;
                err_fired = 1'b1;
            end else if (ack_en && ($urandom_range(99) < 70)) begin
                wbm_ack_i = 1'b1;
                got_q.push_back(mon_cur);
                beat_idx++;
                last_final = (mon_cur.cti == 3'b111);
            end else begin
                held_v = 1'b1;
                held_b = mon_cur;
            end
        end
    end

    always @(negedge clk) if (dst_done) done_cnt++;

    // Reference: split n buffered entries into bursts by the sizing rules
    function automatic int model(input logic [31:0] addr, input int n);
        logic [31:0] a;
        int i, sz, bnd, bursts;
        beat_t b;
        exp_q.delete();
        a = {addr[31:3], 3'b000};
        i = 0;
        bursts = 0;
        while (i < n) begin
            sz = n - i;
            if (sz > 4) sz = 4;
            bnd = (4096 - int'(a[11:0])) / 8;
            if (bnd < sz) sz = bnd;
            for (int k = 0; k < sz; k++) begin
                for (int h = 0; h < 2; h++) begin
                    b.adr = a;
                    b.dat = (h == 0) ? words[i+k][31:0] : words[i+k][63:32];
`ifdef DST_BSWAP_EN
                    b.dat = {b.dat[7:0], b.dat[15:8], b.dat[23:16], b.dat[31:24]};
`endif
                    b.cti = (h == 1 && k == sz - 1) ? 3'b111 : 3'b010;
                    exp_q.push_back(b);
                    a = a + 32'd4;
                end
            end
            i += sz;
            bursts++;
        end
        return bursts;
    endfunction

    task automatic push_word(input logic [63:0] d, input logic l);
        @(negedge clk);
        m_dst_putn = 1'b0;
        m_dst = d;
        m_dst_last = l;
        @(posedge clk);
    endtask

    task automatic end_push();
        @(negedge clk);
        m_dst_putn = 1'b1;
        m_dst_last = 1'b0;
    endtask

    task automatic push_all(input int n);
        for (int i = 0; i < n; i++) push_word(words[i], i == n - 1);
        end_push();
    endtask

    task automatic pulse_start(input logic [31:0] addr);
        @(negedge clk);
        dst_addr = addr;
        dst_start = 1'b1;
        @(negedge clk);
        dst_start = 1'b0;
        chk("busy_after_start", dst_busy, 1);
    endtask

    task automatic wait_done(input int base, input string name);
        int t = 0;
        while (done_cnt == base && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        chk(name, done_cnt - base, 1);
    endtask

    task automatic drain_op(input logic [31:0] addr, input int n, input int exp_b, input string name);
        int mb, nb, base;
        mb = model(addr, n);
        got_q.delete();
        beat_idx = 0;
        base = done_cnt;
        pulse_start(addr);
        wait_done(base, {name, "_done"});
        chk({name, "_nbeats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({name, "_beat"}, got_q[i], exp_q[i]);
        nb = 0;
        foreach (got_q[i]) if (got_q[i].cti == 3'b111) nb++;
        chk({name, "_bursts"}, nb, (exp_b >= 0) ? exp_b : mb);
        chk({name, "_idle"}, {dst_busy, dst_err, dst_ovf, wbm_cyc_o}, 4'b0000);
    endtask

    initial begin
        int base, t;
        logic [31:0] ra;

        tbl[0] = '{32'h0000_1000, 4, 1};
        tbl[1] = '{32'h0000_2000, 1, 1};
        tbl[2] = '{32'h0000_0FF8, 3, 2};
        tbl[3] = '{32'h0000_0FF0, 8, 3};
        tbl[4] = '{32'hFFFF_FFF8, 3, 2};
        tbl[5] = '{32'h0000_3FE0, 5, 2};
        tbl[6] = '{32'h0000_1017, 16, 4};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o, wbm_adr_o, wbm_dat_o},
            {3'b000, 4'hF, 3'b000, 2'b00, 32'h0, 32'h0});
        chk("rst_status", {m_dst_full, m_dst_almost_full, dst_busy, dst_done, dst_err, dst_ovf}, 6'b000000);
        wb_rst_i = 1'b0;

        // vector table
        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < tbl[v].n; j++)
                words[j] = (v == 0) ? 64'(j) : {$urandom, $urandom};
            push_all(tbl[v].n);
            drain_op(tbl[v].addr, tbl[v].n, tbl[v].exp_b, $sformatf("vec%0d", v));
        end

        // full / almost-full / overflow while idle
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16) words[k-1] = {$urandom, $urandom};
            push_word((k <= 16) ? words[k-1] : 64'hDEAD_BEEF_0BAD_F00D, k == 16);
            @(negedge clk);
            m_dst_putn = 1'b1;
            if (k >= 13) begin
                chk($sformatf("almost_full_%0d", k), m_dst_almost_full, k >= 14);
                chk($sformatf("full_%0d", k), m_dst_full, k >= 16);
                chk($sformatf("ovf_%0d", k), dst_ovf, k == 17);
            end
        end
        m_dst_last = 1'b0;
        drain_op(32'h0000_6000, 16, 4, "full_drain");

        // minimum latency from push to strobe
        ack_en = 1'b0;
        got_q.delete();
        beat_idx = 0;
        base = done_cnt;
        pulse_start(32'h0000_5000);
        repeat (2) @(negedge clk);
        push_word({$urandom, $urandom}, 1'b1);
        @(negedge clk);
        m_dst_putn = 1'b1;
        m_dst_last = 1'b0;
        chk("lat_edge_n", wbm_stb_o, 0);
        @(negedge clk);
        chk("lat_edge_n1", wbm_stb_o, 0);
        @(negedge clk);
        chk("lat_edge_n2", {wbm_stb_o, wbm_adr_o}, {1'b1, 32'h0000_5000});
        ack_en = 1'b1;
        wait_done(base, "lat_done");
        chk("lat_nbeats", got_q.size(), 2);

        // bus error on the third beat
        for (int j = 0; j < 4; j++) words[j] = {$urandom, $urandom};
        push_all(4);
        got_q.delete();
        beat_idx = 0;
        err_at = 2;
        err_fired = 1'b0;
        base = done_cnt;
        pulse_start(32'h0000_7000);
        t = 0;
        while (!err_fired && t < 2000) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("err_cyc_drop", {err_fired, wbm_cyc_o, dst_err}, 3'b101);
        chk("err_beats_before", got_q.size(), 2);
        wait_done(base, "err_done");
        chk("err_idle", {dst_busy, dst_err}, 2'b01);
        err_at = -1;
        words[0] = {$urandom, $urandom};
        push_all(1);
        drain_op(32'h0000_2000, 1, 1, "after_err");

        // reset in the middle of a burst
        for (int j = 0; j < 8; j++) words[j] = {$urandom, $urandom};
        push_all(8);
        got_q.delete();
        beat_idx = 0;
        pulse_start(32'h0000_8000);
        t = 0;
        while (got_q.size() < 3 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        wb_rst_i = 1'b1;
        base = done_cnt;
        @(negedge clk);
        wb_rst_i = 1'b0;
        chk("midrst_outputs", {wbm_cyc_o, wbm_stb_o, dst_busy, m_dst_full, m_dst_almost_full}, 5'b00000);
        repeat (5) @(negedge clk);
        chk("midrst_no_done", done_cnt - base, 0);
        for (int j = 0; j < 2; j++) words[j] = {$urandom, $urandom};
        push_all(2);
        drain_op(32'h0000_9000, 2, 1, "after_rst");

        // random operations against the reference model
        for (int r = 0; r < 20; r++) begin
            int n;
            ra = $urandom;
            if ($urandom_range(1) == 1) ra[11:0] = 12'hFFF - 12'($urandom_range(63));
            n = $urandom_range(16, 1);
            for (int j = 0; j < n; j++) words[j] = {$urandom, $urandom};
            push_all(n);
            drain_op(ra, n, -1, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dst_wb_writer.md
Name: dst_wb_writer

Overview:
Destination-side stage directly downstream of the DMA operation core (copy/fill/encode/decode output mux). It buffers the 64-bit m_dst write stream in a small synchronous FIFO and drains it to memory as 32-bit Wishbone incrementing-burst writes, starting at a programmed destination address. Backpressure to the core is given through m_dst_full and m_dst_almost_full. It signals completion once the beat carrying the m_dst_last word is acknowledged.

Parameters:
DEPTH, 16, FIFO entries (64-bit data + last flag); power of 2, minimum 4
AF_MARGIN, 2, m_dst_almost_full asserted when count >= DEPTH-AF_MARGIN
BURST_LEN, 4, 64-bit entries that trigger a burst (2*BURST_LEN Wishbone beats)

Ports:
wb_clk_i  in  1  the block's one clock
wb_rst_i  in  1  synchronous active-high reset
m_dst_putn  in  1  active-low write strobe from core
m_dst  in  64  write data; [31:0] goes to the lower address
m_dst_last  in  1  qualifies final word of the operation
m_dst_full  out  1  FIFO full
m_dst_almost_full  out  1  FIFO at almost-full threshold
dst_addr  in  32  destination byte address, 8-byte aligned (bits [2:0] ignored)
dst_start  in  1  one-cycle pulse: latch dst_addr, arm engine
dst_busy  out  1  armed, last word not yet retired
dst_done  out  1  one-cycle pulse when last beat is acked
dst_err  out  1  sticky: Wishbone error seen
dst_ovf  out  1  sticky: write attempted while full
wbm_adr_o  out  32  byte address
wbm_dat_o  out  32  write data
wbm_sel_o  out  4  always 4'hF
wbm_we_o  out  1  always 1 while cyc
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_cti_o  out  3  3'b010 incrementing, 3'b111 final beat
wbm_bte_o  out  2  always 2'b00 linear
wbm_ack_i  in  1  slave ack
wbm_err_i  in  1  slave error

Behaviour:
- Reset (sync, wb_rst_i=1): FIFO emptied, count=0. All outputs 0 except wbm_sel_o=4'hF. m_dst_full=0, m_dst_almost_full=0 (DEPTH-AF_MARGIN>0). State IDLE.
- Push: m_dst_putn=0 and !m_dst_full writes {m_dst_last,m_dst}. Push with full: data dropped, dst_ovf set. Simultaneous push and pop leaves count unchanged. A push is accepted even when full deasserts in that same cycle only if full was 0 at the edge.
- FIFO tracks lastcnt = number of buffered entries with the last flag set.
- FSM states: IDLE, WAIT, BURST, DONE, ERR.
- IDLE: dst_start -> latch addr, clear dst_err/dst_ovf, go to WAIT, dst_busy=1. dst_start in any other state is ignored.
- WAIT: go to BURST when count >= BURST_LEN or lastcnt != 0. Burst size in entries = min(count, BURST_LEN, entries up to and including the first last-flagged entry, entries before the next 4 KB boundary). Minimum latency: push at edge N, stb asserted after edge N+2.
- BURST: cyc=stb=1. Each entry is sent as two beats, lo word then hi word. wbm_adr_o advances by 4 on each ack. cti=010, or 111 on the final beat of the burst. The entry is popped on the ack of its hi beat. stb, adr and dat are held stable until ack. After the final ack, cyc/stb drop for at least one cycle. If the popped entry had last set, go to DONE, else WAIT.
- DONE: dst_done=1 for one cycle, dst_busy=0, go to IDLE.
- wbm_err_i during a burst: drop cyc/stb next edge, set dst_err, go to ERR. ERR pops and discards FIFO entries at 1 per cycle until a last-flagged entry is discarded, so the core never hangs. Then pulse dst_done and go to IDLE.
- ack and err asserted together: treated as err.
- Pushes while IDLE are buffered but not drained until dst_start.
- Reset mid-burst: cyc/stb low after the reset edge. No completion pulse.
- Address wraps modulo 2^32.

Optional Feature:
DST_BSWAP_EN: when defined, the bytes within each 32-bit beat are reversed before driving wbm_dat_o (byte0<->byte3, byte1<->byte2), for big-endian targets. When undefined, data passes unmodified. Timing and addressing are identical in both builds.

Test Plan:
- dst_start, addr=0x1000; push 4 words 0x0..3 with last on the 4th -> one 8-beat burst at 0x1000..0x101C, cti 010 x7 then 111, dat lo/hi order, then dst_done pulse.
- Push 1 word with last, addr=0x2000 -> 2-beat burst (cti 010 then 111), dst_done 1 cycle after the second ack.
- Hold ack low and push 17 words with DEPTH=16 -> full asserts at 16; almost_full asserts at 14; 17th word dropped; dst_ovf=1.
- addr=0x0FF8, push 3 words with last -> burst of 1 entry to 0xFF8/0xFFC, then a burst of 2 entries from 0x1000.
- Assert wbm_err_i on the 3rd beat -> cyc low next cycle, dst_err=1, remaining words drained through last, dst_done pulses.
- Reset asserted mid-burst -> cyc/stb/busy are 0 after the edge; FIFO empty; a new dst_start runs cleanly.
